// File: rtl/sort_stream_pkg.sv
// Shared types and helpers for the sort_stream frame sorter.
// Holds the controller state encoding and the index-width helper.
package sort_stream_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Smallest r with 2**r >= n; used to size frame indices and pass counters.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sort_stream_cmp_swap.sv
// Compare-exchange cell: lo takes the word that belongs at the lower index.
// Equal words never swap, which keeps the network order-preserving for ties.
module cmp_swap #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             descend,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi
);

  logic a_gt_b;
  logic a_lt_b;
  logic swap;

  if (SIGNED) begin : g_signed
    assign a_gt_b = $signed(a) > $signed(b);
    assign a_lt_b = $signed(a) < $signed(b);
  end else begin : g_unsigned
    assign a_gt_b = a > b;
    assign a_lt_b = a < b;
  end

  assign swap = descend ? a_lt_b : a_gt_b;
  assign lo   = swap ? b : a;
  assign hi   = swap ? a : b;

endmodule

// File: rtl/sort_stream.sv
// Frame sorter: loads DEPTH words, sorts them in place with an odd-even
// transposition network, then streams them out with a valid/ready handshake.
module sort_stream
  import sort_stream_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             descend,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
);

  localparam int IDX_W  = clog2(DEPTH);
  localparam int PASS_W = clog2(DEPTH + 1);
  localparam int NCS    = DEPTH / 2;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [PASS_W-1:0] pass_q, pass_d;
  logic              desc_q, desc_d;
  logic              wr_en;
  logic              sort_en;

  logic [WIDTH-1:0] mem_q  [DEPTH];
  logic [WIDTH-1:0] sorted [DEPTH];
  logic [WIDTH-1:0] cs_a   [NCS];
  logic [WIDTH-1:0] cs_b   [NCS];
  logic [WIDTH-1:0] cs_lo  [NCS];
  logic [WIDTH-1:0] cs_hi  [NCS];

  // Odd passes shift the pairing by one; the last cell has no partner then.
  for (genvar k = 0; k < NCS; k++) begin : g_cs
    if (k < NCS - 1) begin : g_mid
      assign cs_a[k] = pass_q[0] ? mem_q[2*k+1] : mem_q[2*k];
      assign cs_b[k] = pass_q[0] ? mem_q[2*k+2] : mem_q[2*k+1];
    end else begin : g_end
      assign cs_a[k] = mem_q[2*k];
      assign cs_b[k] = mem_q[2*k+1];
    end

    cmp_swap #(
      .WIDTH  (WIDTH),
      .SIGNED (SIGNED)
    ) u_cmp_swap (
      .a       (cs_a[k]),
      .b       (cs_b[k]),
      .descend (desc_q),
      .lo      (cs_lo[k]),
      .hi      (cs_hi[k])
    );
  end

  always_comb begin
    sorted = mem_q;
    if (!pass_q[0]) begin
      for (int k = 0; k < NCS; k++) begin
        sorted[2*k]   = cs_lo[k];
        sorted[2*k+1] = cs_hi[k];
      end
    end else begin
      for (int k = 0; k < NCS - 1; k++) begin
        sorted[2*k+1] = cs_lo[k];
        sorted[2*k+2] = cs_hi[k];
      end
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    state_d   = state_q;
    wr_idx_d  = wr_idx_q;
    rd_idx_d  = rd_idx_q;
    pass_d    = pass_q;
    desc_d    = desc_q;
    wr_en     = 1'b0;
    sort_en   = 1'b0;
    in_ready  = (state_q == LOAD);
    out_valid = (state_q == DRAIN);
    out_last  = (state_q == DRAIN) && (rd_idx_q == IDX_W'(DEPTH - 1));
    busy      = (state_q == SORT) || (state_q == DRAIN);
    out_data  = mem_q[rd_idx_q];

    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          wr_en = 1'b1;
          if (wr_idx_q == '0) desc_d = descend;
          if (wr_idx_q == IDX_W'(DEPTH - 1)) begin
            state_d  = SORT;
            wr_idx_d = '0;
            pass_d   = '0;
          end else begin
            wr_idx_d = wr_idx_q + IDX_W'(1);
          end
        end
      end
      SORT: begin
        // Passes 0..DEPTH-1 exchange; the count of DEPTH is a settle cycle before draining.
        if (pass_q == PASS_W'(DEPTH)) begin
          state_d  = DRAIN;
          rd_idx_d = '0;
        end else begin
          sort_en = 1'b1;
          pass_d  = pass_q + PASS_W'(1);
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (rd_idx_q == IDX_W'(DEPTH - 1)) begin
            state_d  = LOAD;
            rd_idx_d = '0;
          end else begin
            rd_idx_d = rd_idx_q + IDX_W'(1);
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= LOAD;
      wr_idx_q <= '0;
      rd_idx_q <= '0;
      pass_q   <= '0;
      desc_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_idx_q <= wr_idx_d;
      rd_idx_q <= rd_idx_d;
      pass_q   <= pass_d;
      desc_q   <= desc_d;
    end
  end

  // NOTE: the frame buffer has no reset; out_valid gates it, and skipping reset keeps it plain RAM/flops.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx_q] <= in_data;
    end else if (sort_en) begin
      mem_q <= sorted;
    end
  end

endmodule

// File: tb/tb_sort_stream.sv
// Self-checking bench for sort_stream: unsigned and signed instances share
// stimulus; a reference insertion sort fills per-instance scoreboards.
module tb_sort_stream;

  localparam int W = 8;
  localparam int D = 4;

  typedef struct {
    logic [W-1:0] data;
    logic         last;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         descend = 1'b0;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b1;

  logic         ir_u, ov_u, ol_u, bz_u;
  logic [W-1:0] od_u;
  logic         ir_s, ov_s, ol_s, bz_s;
  logic [W-1:0] od_s;

  exp_t exp_u[$];
  exp_t exp_s[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_acc_cyc = 0;
  bit prev_hs_last = 1'b0;
  bit prev_ov = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sort_stream #(.WIDTH(W), .DEPTH(D), .SIGNED(1'b0)) dut_u (
    .clk(clk), .rst(rst), .descend(descend), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir_u), .out_valid(ov_u), .out_data(od_u), .out_last(ol_u),
    .out_ready(out_ready), .busy(bz_u)
  );

  sort_stream #(.WIDTH(W), .DEPTH(D), .SIGNED(1'b1)) dut_s (
    .clk(clk), .rst(rst), .descend(descend), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir_s), .out_valid(ov_s), .out_data(od_s), .out_last(ol_s),
    .out_ready(out_ready), .busy(bz_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit precedes(input logic [W-1:0] x, input logic [W-1:0] y,
                                  input bit sgn, input bit desc);
    if (sgn) return desc ? ($signed(x) > $signed(y)) : ($signed(x) < $signed(y));
    return desc ? (x > y) : (x < y);
  endfunction

  task automatic push_expected(input logic [W-1:0] w[D], input bit sgn, input bit desc);
    logic [W-1:0] a[D];
    logic [W-1:0] key;
    int j;
    exp_t e;
    a = w;
    for (int i = 1; i < D; i++) begin
      key = a[i];
      j = i - 1;
      while (j >= 0 && precedes(key, a[j], sgn, desc)) begin
        a[j+1] = a[j];
        j--;
      end
      a[j+1] = key;
    end
    for (int i = 0; i < D; i++) begin
      e.data = a[i];
      e.last = (i == D - 1);
      if (sgn) exp_s.push_back(e);
      else     exp_u.push_back(e);
    end
  endtask

  // Presents one word and returns #1 after the edge that accepted it.
  task automatic send_word(input logic [W-1:0] w);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = w;
    @(negedge clk);
    while (!ir_u) begin
      n++;
      if (n > 200) begin
        check("accept_timeout", 0, 1);
        return;
      end
      @(negedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  // descend is flipped after the first accept; the frame must keep the first value.
  task automatic send_frame(input logic [W-1:0] w0, input logic [W-1:0] w1,
                            input logic [W-1:0] w2, input logic [W-1:0] w3,
                            input bit desc, input bit keep_valid);
    logic [W-1:0] w[D];
    w = '{w0, w1, w2, w3};
    descend = desc;
    send_word(w[0]);
    descend = ~desc;
    for (int i = 1; i < D; i++) send_word(w[i]);
    last_acc_cyc = cyc;
    if (!keep_valid) in_valid = 1'b0;
    push_expected(w, 1'b0, desc);
    push_expected(w, 1'b1, desc);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_u.size() != 0 || exp_s.size() != 0) begin
      n++;
      if (n > 300) begin
        check("drain_timeout", 0, 1);
        exp_u.delete();
        exp_s.delete();
        return;
      end
      @(posedge clk);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_hs_last = 1'b0;
      prev_ov      = 1'b0;
    end else begin
      if (prev_hs_last) begin
        check("in_ready_after_last", ir_u, 1);
        check("out_valid_after_last", ov_u, 0);
      end
      if (ov_u && !prev_ov) check("first_valid_latency", cyc - last_acc_cyc, D + 1);
      if (ov_u && out_ready) begin
        if (exp_u.size() == 0) check("unexpected_out_u", od_u, 32'hDEAD);
        else begin
          e = exp_u.pop_front();
          check("data_u", od_u, e.data);
          check("last_u", ol_u, e.last);
        end
      end
      if (ov_s && out_ready) begin
        if (exp_s.size() == 0) check("unexpected_out_s", od_s, 32'hDEAD);
        else begin
          e = exp_s.pop_front();
          check("data_s", od_s, e.data);
          check("last_s", ol_s, e.last);
        end
      end
      prev_hs_last = ov_u && out_ready && ol_u;
      prev_ov      = ov_u;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] held_d;
    logic         held_l;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_in_ready", ir_u, 1);
    check("rst_out_valid", ov_u, 0);
    check("rst_out_last", ol_u, 0);
    check("rst_busy", bz_u, 0);
    check("rst_busy_s", bz_s, 0);

    // Basic ascending frame, and signed vs unsigned ordering.
    send_frame(8'd3, 8'd1, 8'd4, 8'd2, 1'b0, 1'b0);
    @(negedge clk);
    check("busy_in_sort", bz_u, 1);
    check("in_ready_in_sort", ir_u, 0);
    wait_drain();
    send_frame(8'hFF, 8'h01, 8'h80, 8'h00, 1'b0, 1'b0);
    wait_drain();

    // Descending with duplicates.
    send_frame(8'd5, 8'd5, 8'd2, 8'd9, 1'b1, 1'b0);
    wait_drain();

    // Back-pressure: out_ready low for three DRAIN cycles; junk on the input is ignored.
    out_ready = 1'b0;
    send_frame(8'd10, 8'd40, 8'd20, 8'd30, 1'b0, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hEE;
    begin
      int n;
      n = 0;
      @(negedge clk);
      while (!ov_u && n < 50) begin n++; @(negedge clk); end
    end
    check("stall_valid_seen", ov_u, 1);
    check("stall_first_data", od_u, exp_u[0].data);
    held_d = od_u;
    held_l = ol_u;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_data_hold", od_u, held_d);
      check("stall_valid_hold", ov_u, 1);
      check("stall_last_hold", ol_u, held_l);
      check("stall_in_ready", ir_u, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    wait_drain();

    // Reset during SORT pass 2 discards the frame.
    send_frame(8'd9, 8'd8, 8'd1, 8'd2, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_u.delete();
    exp_s.delete();
    check("midsort_rst_out_valid", ov_u, 0);
    check("midsort_rst_in_ready", ir_u, 1);
    check("midsort_rst_busy", bz_u, 0);
    send_frame(8'd7, 8'd6, 8'd5, 8'd4, 1'b0, 1'b0);
    wait_drain();

    // Back-to-back frames with in_valid held high throughout.
    send_frame(8'd12, 8'd3, 8'd200, 8'd3, 1'b0, 1'b1);
    send_frame(8'h7F, 8'h81, 8'h00, 8'hC0, 1'b1, 1'b1);
    send_frame(8'd1, 8'd2, 8'd3, 8'd4, 1'b1, 1'b0);
    wait_drain();

    check("scoreboard_empty_u", exp_u.size(), 0);
    check("scoreboard_empty_s", exp_s.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
